// File: rtl/slot_pulser_pkg.sv
// slot_pulser_pkg: shared widths, FSM state encoding and burst-phase helpers
// for the slot_pulser time-slot sequencer.
//   TS_W   : width of slot period and hush counters
//   PH_W   : width of hit/gnd phase lengths
//   CNT_W  : width of the pulse pair count
//   TS_MIN : smallest slot period the timer will run
// Optional build macro: SLOT_PULSER_DEADTIME_EN adds the ST_DEAD state.
package slot_pulser_pkg;

    localparam int TS_W  = 16;
    localparam int PH_W  = 8;
    localparam int CNT_W = 4;

    localparam logic [TS_W-1:0]  TS_MIN  = 16'd2;
    localparam logic [TS_W-1:0]  LEN_ONE = 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIT    = 3'd1,
        ST_GND    = 3'd2,
        ST_HUSH   = 3'd3,
        ST_LISTEN = 3'd4
`ifdef SLOT_PULSER_DEADTIME_EN
        , ST_DEAD = 3'd5
`endif
    } state_t;

    // Where the burst goes next when a phase is entered: target state,
    // its length in ticks, which drive line is active and the ADC strobe.
    typedef struct packed {
        state_t          st;
        logic [TS_W-1:0] len;
        logic            drv_p;
        logic            drv_n;
        logic            adc;
    } entry_t;

    function automatic logic [TS_W-1:0] clamp_period(input logic [TS_W-1:0] t);
        return (t < TS_MIN) ? TS_MIN : t;
    endfunction

    function automatic logic is_busy(input state_t s);
        logic b;
        case (s)
            ST_HIT, ST_GND, ST_HUSH: b = 1'b1;
`ifdef SLOT_PULSER_DEADTIME_EN
            ST_DEAD:                 b = 1'b1;
`endif
            default:                 b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic entry_t idle_entry();
        entry_t e;
        e.st    = ST_IDLE;
        e.len   = {TS_W{1'b0}};
        e.drv_p = 1'b0;
        e.drv_n = 1'b0;
        e.adc   = 1'b0;
        return e;
    endfunction

    // Zero hush collapses straight into LISTEN with the ADC strobe.
    function automatic entry_t hush_entry(input logic [TS_W-1:0] hush);
        entry_t e;
        e = idle_entry();
        if (hush != {TS_W{1'b0}}) begin
            e.st  = ST_HUSH;
            e.len = hush;
        end else begin
            e.st  = ST_LISTEN;
            e.adc = 1'b1;
        end
        return e;
    endfunction

    // Start of a hit/gnd pair; zero-length phases are skipped entirely.
    function automatic entry_t pair_entry(input logic [PH_W-1:0] hit,
                                          input logic [PH_W-1:0] gnd,
                                          input logic [TS_W-1:0] hush);
        entry_t e;
        e = idle_entry();
        if (hit != {PH_W{1'b0}}) begin
            e.st    = ST_HIT;
            e.len   = {{(TS_W-PH_W){1'b0}}, hit};
            e.drv_p = 1'b1;
        end else if (gnd != {PH_W{1'b0}}) begin
            e.st    = ST_GND;
            e.len   = {{(TS_W-PH_W){1'b0}}, gnd};
            e.drv_n = 1'b1;
        end else begin
            e = hush_entry(hush);
        end
        return e;
    endfunction

    // Gnd half of the current pair; with gnd=0 the pair is already complete.
    function automatic entry_t gnd_entry(input logic [PH_W-1:0] hit,
                                         input logic [PH_W-1:0] gnd,
                                         input logic [TS_W-1:0] hush,
                                         input logic            more);
        entry_t e;
        e = idle_entry();
        if (gnd != {PH_W{1'b0}}) begin
            e.st    = ST_GND;
            e.len   = {{(TS_W-PH_W){1'b0}}, gnd};
            e.drv_n = 1'b1;
        end else if (more) begin
            e = pair_entry(hit, gnd, hush);
        end else begin
            e = hush_entry(hush);
        end
        return e;
    endfunction

endpackage

// File: rtl/slot_pulser_slot_timer.sv
// slot_timer: slot period counter and slot index sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   i_enable            : run enable; low holds the counter at 0 and o_slot
//   i_ts_time_0..3      : per-slot periods in ticks (clamped to TS_MIN)
//   o_slot              : current slot index (registered)
//   o_slot_start        : registered strobe in cycle 0 of each slot
//   o_slot_last         : combinational flag, current cycle is the slot's last
module slot_timer
    import slot_pulser_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_enable,
    input  logic [TS_W-1:0] i_ts_time_0,
    input  logic [TS_W-1:0] i_ts_time_1,
    input  logic [TS_W-1:0] i_ts_time_2,
    input  logic [TS_W-1:0] i_ts_time_3,
    output logic [1:0]      o_slot,
    output logic            o_slot_start,
    output logic            o_slot_last
);

    logic [TS_W-1:0] cnt_r;
    logic [TS_W-1:0] period_r;
    logic [TS_W-1:0] ts_sel_s;
    logic [1:0]      slot_r;
    logic            start_r;
    logic            run_r;

    // Period input belonging to the slot currently presented on o_slot
    always_comb begin
        ts_sel_s = i_ts_time_0;
        case (slot_r)
            2'd0:    ts_sel_s = i_ts_time_0;
            2'd1:    ts_sel_s = i_ts_time_1;
            2'd2:    ts_sel_s = i_ts_time_2;
            default: ts_sel_s = i_ts_time_3;
        endcase
    end

    // Cycle 0 is never the last one because the period is at least TS_MIN,
    // so the stale period_r seen during cycle 0 cannot end the slot early.
    assign o_slot_last = run_r & ~start_r & (cnt_r == (period_r - LEN_ONE));

    // Tick counter, slot advance and cycle-0 strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {TS_W{1'b0}};
            slot_r  <= 2'd0;
            start_r <= 1'b0;
            run_r   <= 1'b0;
        end else if (!i_enable) begin
            cnt_r   <= {TS_W{1'b0}};
            start_r <= 1'b0;
            run_r   <= 1'b0;
        end else if (!run_r) begin
            run_r   <= 1'b1;
            cnt_r   <= {TS_W{1'b0}};
            start_r <= 1'b1;
        end else if (o_slot_last) begin
            cnt_r   <= {TS_W{1'b0}};
            slot_r  <= slot_r + 2'd1;
            start_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + LEN_ONE;
            start_r <= 1'b0;
        end
    end

    // Period of the running slot, captured in its cycle 0
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r <= TS_MIN;
        end else if (start_r) begin
            period_r <= clamp_period(ts_sel_s);
        end else begin
            period_r <= period_r;
        end
    end

    assign o_slot       = slot_r;
    assign o_slot_start = start_r;

endmodule

// File: rtl/slot_pulser.sv
// slot_pulser: time-slot sequencer and pulse-burst generator for one probe bank.
// Each slot: hit/gnd drive pairs on the masked lines, a hush blanking period,
// then a one-cycle ADC start strobe; the burst is aborted if the slot ends first.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_enable                 : run enable
//   i_ts_time_0..3           : slot periods in ticks
//   i_pulse_mask/hit/gnd/count/hush : current slot's burst parameters
//   o_slot, o_slot_start     : slot index and cycle-0 strobe
//   o_pulse_p, o_pulse_n     : hit-phase / gnd-phase drives
//   o_adc_start, o_overrun   : acquisition strobe, aborted-burst strobe
//   o_busy                   : high while a burst is in progress
// Build option: define SLOT_PULSER_DEADTIME_EN to insert one dead cycle at
// every HIT->GND and GND->HIT transition.
module slot_pulser
    import slot_pulser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    output logic [1:0]       o_slot,
    input  logic [TS_W-1:0]  i_ts_time_0,
    input  logic [TS_W-1:0]  i_ts_time_1,
    input  logic [TS_W-1:0]  i_ts_time_2,
    input  logic [TS_W-1:0]  i_ts_time_3,
    input  logic [3:0]       i_pulse_mask,
    input  logic [PH_W-1:0]  i_pulse_hit,
    input  logic [PH_W-1:0]  i_pulse_gnd,
    input  logic [CNT_W-1:0] i_pulse_count,
    input  logic [TS_W-1:0]  i_pulse_hush,
    output logic [3:0]       o_pulse_p,
    output logic [3:0]       o_pulse_n,
    output logic             o_slot_start,
    output logic             o_adc_start,
    output logic             o_overrun,
    output logic             o_busy
);

    logic             slot_start_s;
    logic             slot_last_s;

    state_t           state_r;
    logic [TS_W-1:0]  ph_r;
    logic [CNT_W-1:0] pairs_r;
    logic [3:0]       mask_r;
    logic [PH_W-1:0]  hit_r;
    logic [PH_W-1:0]  gnd_r;
    logic [CNT_W-1:0] count_r;
    logic [TS_W-1:0]  hush_r;
    logic [3:0]       p_r;
    logic [3:0]       n_r;
    logic             adc_r;
    logic             ovr_r;
`ifdef SLOT_PULSER_DEADTIME_EN
    logic             dead_to_gnd_r;
    logic             dead_needed_s;
`endif

    logic [3:0]       eff_mask_s;
    logic [PH_W-1:0]  eff_hit_s;
    logic [PH_W-1:0]  eff_gnd_s;
    logic [CNT_W-1:0] eff_count_s;
    logic [TS_W-1:0]  eff_hush_s;
    logic             more_s;
    logic             pair_done_s;
    entry_t           sel_e_s;

    slot_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_ts_time_0  (i_ts_time_0),
        .i_ts_time_1  (i_ts_time_1),
        .i_ts_time_2  (i_ts_time_2),
        .i_ts_time_3  (i_ts_time_3),
        .o_slot       (o_slot),
        .o_slot_start (slot_start_s),
        .o_slot_last  (slot_last_s)
    );

    // In cycle 0 the parameter block already reflects the new slot, so the
    // first phase decision uses the live inputs; later cycles use the latches.
    assign eff_mask_s  = slot_start_s ? i_pulse_mask  : mask_r;
    assign eff_hit_s   = slot_start_s ? i_pulse_hit   : hit_r;
    assign eff_gnd_s   = slot_start_s ? i_pulse_gnd   : gnd_r;
    assign eff_count_s = slot_start_s ? i_pulse_count : count_r;
    assign eff_hush_s  = slot_start_s ? i_pulse_hush  : hush_r;

    // pairs_r counts the current pair too, so "more" means another pair follows
    assign more_s = (pairs_r > CNT_ONE);

    // Phase that follows the one ending in the current state
    always_comb begin
        sel_e_s = idle_entry();
        case (state_r)
            ST_IDLE: begin
                if (eff_count_s == {CNT_W{1'b0}}) begin
                    sel_e_s = hush_entry(eff_hush_s);
                end else begin
                    sel_e_s = pair_entry(eff_hit_s, eff_gnd_s, eff_hush_s);
                end
            end
            ST_HIT:  sel_e_s = gnd_entry(eff_hit_s, eff_gnd_s, eff_hush_s, more_s);
            ST_GND: begin
                if (more_s) begin
                    sel_e_s = pair_entry(eff_hit_s, eff_gnd_s, eff_hush_s);
                end else begin
                    sel_e_s = hush_entry(eff_hush_s);
                end
            end
            ST_HUSH: sel_e_s = hush_entry({TS_W{1'b0}});
`ifdef SLOT_PULSER_DEADTIME_EN
            ST_DEAD: begin
                if (dead_to_gnd_r) begin
                    sel_e_s = gnd_entry(eff_hit_s, eff_gnd_s, eff_hush_s, more_s);
                end else begin
                    sel_e_s = pair_entry(eff_hit_s, eff_gnd_s, eff_hush_s);
                end
            end
`endif
            default: sel_e_s = idle_entry();
        endcase
    end

    // A pair completes at the end of GND, or at the end of HIT when gnd=0
    assign pair_done_s = (state_r == ST_GND) |
                         ((state_r == ST_HIT) & (sel_e_s.st != ST_GND));

`ifdef SLOT_PULSER_DEADTIME_EN
    assign dead_needed_s = ((state_r == ST_HIT) & (sel_e_s.st == ST_GND)) |
                           ((state_r == ST_GND) & (sel_e_s.st == ST_HIT));
`endif

    // Burst FSM with registered drive, ADC and overrun outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ph_r    <= {TS_W{1'b0}};
            pairs_r <= {CNT_W{1'b0}};
            mask_r  <= 4'b0000;
            hit_r   <= {PH_W{1'b0}};
            gnd_r   <= {PH_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            hush_r  <= {TS_W{1'b0}};
            p_r     <= 4'b0000;
            n_r     <= 4'b0000;
            adc_r   <= 1'b0;
            ovr_r   <= 1'b0;
`ifdef SLOT_PULSER_DEADTIME_EN
            dead_to_gnd_r <= 1'b0;
`endif
        end else if (!i_enable) begin
            state_r <= ST_IDLE;
            p_r     <= 4'b0000;
            n_r     <= 4'b0000;
            adc_r   <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (slot_last_s) begin
            // Slot ends: anything short of LISTEN is an aborted burst
            state_r <= ST_IDLE;
            p_r     <= 4'b0000;
            n_r     <= 4'b0000;
            adc_r   <= 1'b0;
            ovr_r   <= is_busy(state_r);
        end else begin
            adc_r <= 1'b0;
            ovr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (slot_start_s) begin
                        mask_r  <= i_pulse_mask;
                        hit_r   <= i_pulse_hit;
                        gnd_r   <= i_pulse_gnd;
                        count_r <= i_pulse_count;
                        hush_r  <= i_pulse_hush;
                        pairs_r <= i_pulse_count;
                        state_r <= sel_e_s.st;
                        ph_r    <= sel_e_s.len;
                        p_r     <= sel_e_s.drv_p ? eff_mask_s : 4'b0000;
                        n_r     <= sel_e_s.drv_n ? eff_mask_s : 4'b0000;
                        adc_r   <= sel_e_s.adc;
                    end else begin
                        p_r <= 4'b0000;
                        n_r <= 4'b0000;
                    end
                end
                ST_HIT, ST_GND, ST_HUSH: begin
                    if (ph_r > LEN_ONE) begin
                        ph_r <= ph_r - LEN_ONE;
                    end else begin
                        if (pair_done_s) begin
                            pairs_r <= pairs_r - CNT_ONE;
                        end
`ifdef SLOT_PULSER_DEADTIME_EN
                        if (dead_needed_s) begin
                            state_r       <= ST_DEAD;
                            dead_to_gnd_r <= (state_r == ST_HIT);
                            p_r           <= 4'b0000;
                            n_r           <= 4'b0000;
                        end else
`endif
                        begin
                            state_r <= sel_e_s.st;
                            ph_r    <= sel_e_s.len;
                            p_r     <= sel_e_s.drv_p ? eff_mask_s : 4'b0000;
                            n_r     <= sel_e_s.drv_n ? eff_mask_s : 4'b0000;
                            adc_r   <= sel_e_s.adc;
                        end
                    end
                end
`ifdef SLOT_PULSER_DEADTIME_EN
                ST_DEAD: begin
                    state_r <= sel_e_s.st;
                    ph_r    <= sel_e_s.len;
                    p_r     <= sel_e_s.drv_p ? eff_mask_s : 4'b0000;
                    n_r     <= sel_e_s.drv_n ? eff_mask_s : 4'b0000;
                    adc_r   <= sel_e_s.adc;
                end
`endif
                ST_LISTEN: begin
                    p_r <= 4'b0000;
                    n_r <= 4'b0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                    p_r     <= 4'b0000;
                    n_r     <= 4'b0000;
                end
            endcase
        end
    end

    assign o_slot_start = slot_start_s;
    assign o_pulse_p    = p_r;
    assign o_pulse_n    = n_r;
    assign o_adc_start  = adc_r;
    assign o_overrun    = ovr_r;
    assign o_busy       = is_busy(state_r);

endmodule

// File: tb/tb_slot_pulser.sv
// tb_slot_pulser: directed scoreboard bench for slot_pulser. Expected
// per-cycle output words come from a small burst timeline model and are
// queued as stimulus is applied, then popped one per clock and compared.
module tb_slot_pulser;

`ifdef SLOT_PULSER_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [1:0]  o_slot;
    logic [15:0] i_ts_time_0, i_ts_time_1, i_ts_time_2, i_ts_time_3;
    logic [3:0]  i_pulse_mask;
    logic [7:0]  i_pulse_hit, i_pulse_gnd;
    logic [3:0]  i_pulse_count;
    logic [15:0] i_pulse_hush;
    logic [3:0]  o_pulse_p, o_pulse_n;
    logic        o_slot_start, o_adc_start, o_overrun, o_busy;

    // {slot[1:0], slot_start, p[3:0], n[3:0], adc, overrun, busy}
    logic [13:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    slot_pulser dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .o_slot(o_slot),
        .i_ts_time_0(i_ts_time_0), .i_ts_time_1(i_ts_time_1),
        .i_ts_time_2(i_ts_time_2), .i_ts_time_3(i_ts_time_3),
        .i_pulse_mask(i_pulse_mask), .i_pulse_hit(i_pulse_hit),
        .i_pulse_gnd(i_pulse_gnd), .i_pulse_count(i_pulse_count),
        .i_pulse_hush(i_pulse_hush), .o_pulse_p(o_pulse_p),
        .o_pulse_n(o_pulse_n), .o_slot_start(o_slot_start),
        .o_adc_start(o_adc_start), .o_overrun(o_overrun), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Expected outputs in cycle c of a slot of period T, from the driven burst settings
    function automatic logic [13:0] model_cycle(int T, logic [1:0] slot, bit ov_in, int c);
        logic [3:0] p, n;
        bit adc, busy, st, ov;
        int t, hit, gnd, cnt, adc_t;
        hit = int'(i_pulse_hit);
        gnd = int'(i_pulse_gnd);
        cnt = int'(i_pulse_count);
        p = 4'd0; n = 4'd0; adc = 1'b0; busy = 1'b0;
        st = (c == 0);
        ov = (c == 0) ? ov_in : 1'b0;
        t = 1;
        for (int k = 0; k < cnt; k++) begin
            for (int i = 0; i < hit; i++) begin
                if (t == c) p = i_pulse_mask;
                t++;
            end
            if (DEAD_EN && hit > 0 && gnd > 0) t++;
            for (int i = 0; i < gnd; i++) begin
                if (t == c) n = i_pulse_mask;
                t++;
            end
            if (DEAD_EN && hit > 0 && gnd > 0 && k < cnt - 1) t++;
        end
        adc_t = t + int'(i_pulse_hush);
        if (c == adc_t && c < T) adc = 1'b1;
        if (c >= 1 && c < adc_t) busy = 1'b1;
        return {slot, st, p, n, adc, ov, busy};
    endfunction

    task automatic push_slot(int T, logic [1:0] slot, bit ov_in, int c_from, int c_to);
        for (int c = c_from; c <= c_to; c++) exp_q.push_back(model_cycle(T, slot, ov_in, c));
    endtask

    task automatic push_idle(logic [1:0] slot);
        exp_q.push_back({slot, 12'd0});
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge
    task automatic step_check(string tag, int n);
        logic [13:0] exp_v, obs_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            total++;
            obs_v = {o_slot, o_slot_start, o_pulse_p, o_pulse_n, o_adc_start, o_overrun, o_busy};
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL %s step=%0d scoreboard empty observed=%h", tag, i, obs_v);
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                assert (obs_v === exp_v) else begin
                    bad++;
                    $error("FAIL %s step=%0d observed=%h expected=%h", tag, i, obs_v, exp_v);
                end
            end
        end
    endtask

    task automatic set_burst(int h, int g, int cnt, int hush, logic [3:0] m);
        i_pulse_hit   = 8'(h);
        i_pulse_gnd   = 8'(g);
        i_pulse_count = 4'(cnt);
        i_pulse_hush  = 16'(hush);
        i_pulse_mask  = m;
    endtask

    task automatic set_ts(int t0, int t1, int t2, int t3);
        i_ts_time_0 = 16'(t0);
        i_ts_time_1 = 16'(t1);
        i_ts_time_2 = 16'(t2);
        i_ts_time_3 = 16'(t3);
    endtask

    task automatic restart();
        i_enable = 1'b0;
        rst = 1'b1;
        push_idle(2'd0);
        step_check("restart", 1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        set_ts(40, 40, 40, 40);
        set_burst(2, 3, 2, 4, 4'b0001);
        push_idle(2'd0);
        step_check("reset", 1);

        // Basic burst over a full 40-tick slot, into cycle 0 of slot 1
        rst = 1'b0;
        i_enable = 1'b1;
        push_slot(40, 2'd0, 1'b0, 0, 39);
        push_slot(40, 2'd1, 1'b0, 0, 0);
        step_check("basic", 41);

        // Reset raised in cycle 4 of slot 1
        push_slot(40, 2'd1, 1'b0, 1, 4);
        step_check("pre_rst", 4);
        rst = 1'b1;
        push_idle(2'd0);
        step_check("rst_mid", 1);
        rst = 1'b0;
        push_slot(40, 2'd0, 1'b0, 0, 2);
        step_check("rst_resume", 3);

        // Enable dropped in cycle 4, then restored
        push_slot(40, 2'd0, 1'b0, 3, 4);
        step_check("pre_en", 2);
        i_enable = 1'b0;
        push_idle(2'd0);
        step_check("en_low", 1);
        i_enable = 1'b1;
        push_slot(40, 2'd0, 1'b0, 0, 5);
        step_check("en_resume", 6);

        // Overrun: same burst in a 10-tick slot
        restart();
        set_ts(10, 40, 40, 40);
        i_enable = 1'b1;
        push_slot(10, 2'd0, 1'b0, 0, 9);
        push_slot(40, 2'd1, 1'b1, 0, 3);
        step_check("overrun", 14);

        // Wrap with count=0, hush=0 (ADC start in cycle 1, no drives)
        restart();
        set_ts(10, 10, 10, 6);
        set_burst(2, 3, 0, 0, 4'b1111);
        i_enable = 1'b1;
        push_slot(10, 2'd0, 1'b0, 0, 9);
        push_slot(10, 2'd1, 1'b0, 0, 9);
        push_slot(10, 2'd2, 1'b0, 0, 9);
        push_slot(6,  2'd3, 1'b0, 0, 5);
        push_slot(10, 2'd0, 1'b0, 0, 0);
        step_check("wrap", 37);

        // hit=0: gnd pulses only
        restart();
        set_ts(20, 20, 20, 20);
        set_burst(0, 3, 2, 2, 4'b1010);
        i_enable = 1'b1;
        push_slot(20, 2'd0, 1'b0, 0, 19);
        push_slot(20, 2'd1, 1'b0, 0, 0);
        step_check("hit_zero", 21);

        // ts=0 clamps to a 2-tick period
        restart();
        set_ts(0, 0, 0, 0);
        set_burst(2, 3, 0, 0, 4'b0001);
        i_enable = 1'b1;
        push_slot(2, 2'd0, 1'b0, 0, 1);
        push_slot(2, 2'd1, 1'b0, 0, 1);
        push_slot(2, 2'd2, 1'b0, 0, 0);
        step_check("ts_zero", 5);

        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL leftover observed=%0d expected=0", exp_q.size());
        end
        total++;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
